// File: rtl/sram_read_streamer_if.sv
// rtl/sram_read_streamer_if.sv - request, SRAM and output-stream signals of sram_read_streamer
// m_last_o exists only when SRAM_STREAM_LAST_EN is defined.
`timescale 1ns/1ps
interface sram_read_streamer_if #(
    parameter int AW        = 10,
    parameter int OUT_WIDTH = 64
);
    logic                 start_i;
    logic [AW-1:0]        base_addr_i;
    logic [AW:0]          len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 sram_en_o;
    logic                 sram_we_o;
    logic [AW-1:0]        sram_addr_o;
    logic [OUT_WIDTH-1:0] sram_data_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [OUT_WIDTH-1:0] m_data_o;
`ifdef SRAM_STREAM_LAST_EN
    logic                 m_last_o;
`endif

    modport master (
        input  start_i, base_addr_i, len_i, sram_data_i, m_ready_i,
        output busy_o, done_o, sram_en_o, sram_we_o, sram_addr_o, m_valid_o, m_data_o
`ifdef SRAM_STREAM_LAST_EN
        , output m_last_o
`endif
    );

    modport slave (
        output start_i, base_addr_i, len_i, sram_data_i, m_ready_i,
        input  busy_o, done_o, sram_en_o, sram_we_o, sram_addr_o, m_valid_o, m_data_o
`ifdef SRAM_STREAM_LAST_EN
        , input m_last_o
`endif
    );
endinterface

// File: rtl/sram_read_streamer.sv
// rtl/sram_read_streamer.sv - SRAM burst reader streaming wide words through a 2-entry FIFO
// Optional: define SRAM_STREAM_LAST_EN to add m_last_o on the final word of a burst.
`timescale 1ns/1ps
module sram_read_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    sram_read_streamer_if.master bus
);
    localparam int ELEMS = OUT_WIDTH / DATA_WIDTH;
    localparam int AW    = $clog2(N_ENTRIES);
    localparam logic [AW-1:0] STEP = AW'(ELEMS);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [OUT_WIDTH-1:0] mem [2];
    logic [1:0]           cnt;
    logic                 rd_ptr, wr_ptr;
    logic                 pend;
    logic [AW:0]          rd_left, word_left;
    logic [AW-1:0]        addr_q, addr_nx;
    logic                 done_q;
    logic                 issue, pop, push;
    logic [2:0]           occ;

    assign pop  = (cnt != 2'd0) && bus.m_ready_i;
    assign push = pend;
    // Occupancy this read will see once the current cycle's pop has left the FIFO.
    assign occ  = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        addr_nx  = addr_q + STEP;
        unique case (state)
            IDLE: begin
                addr_nx = bus.base_addr_i;
                if (rst_n_i && bus.start_i && (bus.len_i != '0)) begin
                    issue    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                issue = (rd_left != '0) && (occ < 3'd2);
                if ((rd_left == '0) || (issue && (rd_left == ONE)))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && (word_left == ONE))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            pend      <= 1'b0;
            rd_left   <= '0;
            word_left <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            state  <= state_nx;
            done_q <= ((state == IDLE) && bus.start_i && (bus.len_i == '0)) ||
                      ((state == DRAIN) && (state_nx == IDLE));
            pend   <= issue;
            if (issue)
                addr_q <= addr_nx;
            if ((state == IDLE) && issue) begin
                rd_left   <= bus.len_i - ONE;
                word_left <= bus.len_i;
            end else begin
                if (issue)
                    rd_left <= rd_left - ONE;
                if (pop)
                    word_left <= word_left - ONE;
            end
            if (push) begin
                mem[wr_ptr] <= bus.sram_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = done_q;
    assign bus.sram_en_o   = issue;
    assign bus.sram_we_o   = 1'b0;
    assign bus.sram_addr_o = issue ? addr_nx : addr_q;
    assign bus.m_valid_o   = (cnt != 2'd0);
    assign bus.m_data_o    = mem[rd_ptr];

`ifdef SRAM_STREAM_LAST_EN
    logic pend_last;
    logic last_q [2];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_last <= 1'b0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
        end else begin
            pend_last <= issue && ((state == IDLE) ? (bus.len_i == ONE) : (rd_left == ONE));
            if (push)
                last_q[wr_ptr] <= pend_last;
        end
    end

    assign bus.m_last_o = (cnt != 2'd0) && last_q[rd_ptr];
`endif
endmodule

// File: tb/tb_sram_read_streamer.sv
// tb/tb_sram_read_streamer.sv - scoreboard bench for sram_read_streamer
// Define SRAM_STREAM_LAST_EN to also check m_last_o.
`timescale 1ns/1ps
module tb_sram_read_streamer;
    localparam int AW    = 10;
    localparam int OW    = 64;
    localparam int N     = 1024;
    localparam int ELEMS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_read_streamer_if #(.AW(AW), .OUT_WIDTH(OW)) bus ();

    sram_read_streamer #(.DATA_WIDTH(32), .N_ENTRIES(N), .OUT_WIDTH(OW)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    function automatic logic [63:0] word_of(input int a);
        logic [31:0] w;
        w = 32'(a);
        return {w ^ 32'hA5A5_0000, (w * 32'd3) + 32'h1000_0007};
    endfunction

    // One-cycle-latency SRAM model
    always @(posedge clk)
        if (bus.sram_en_o)
            bus.sram_data_i <= word_of(int'(bus.sram_addr_o));

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_cyc = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          issued = 0;
    int          popped = 0;
    bit          done_seen = 0;
    bit          first_seen = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;
    int          addrq [$];
    logic [63:0] expq [$];
    bit          lastq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        int pop_now;
        bit e;
        if (!rst_n) return;
        pop_now = (bus.m_valid_o && bus.m_ready_i) ? 1 : 0;
        if (bus.sram_en_o) begin
            check("occ_lt2", 64'((issued - popped - pop_now) < 2), 64'd1);
            check("we_low", 64'(bus.sram_we_o), 64'd0);
            if (addrq.size() == 0) check("addr_extra", 64'd1, 64'd0);
            else                   check("addr", 64'(bus.sram_addr_o), 64'(addrq.pop_front()));
            issued++;
        end
        if (bus.m_valid_o) begin
            if (!first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (prev_stall) check("stable", bus.m_data_o, prev_data);
        end
`ifdef SRAM_STREAM_LAST_EN
        else check("last_idle", 64'(bus.m_last_o), 64'd0);
`endif
        if (pop_now != 0) begin
            if (expq.size() == 0) check("data_extra", 64'd1, 64'd0);
            else                  check("data", bus.m_data_o, expq.pop_front());
            if (lastq.size() > 0) begin
                e = lastq.pop_front();
`ifdef SRAM_STREAM_LAST_EN
                check("last", 64'(bus.m_last_o), 64'(e));
`endif
            end
            popped++;
            last_hs_cyc = cyc;
        end
        prev_stall = bus.m_valid_o && !bus.m_ready_i;
        prev_data  = bus.m_data_o;
        if (bus.done_o) begin
            if (cyc > start_cyc) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            check("busy_at_done", 64'(bus.busy_o), 64'd0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // mode 0: ready held 1; mode 1: ready toggles 1010; mode 2: ready 1 plus a start while busy
    task automatic run_burst(input int base, input int len, input int mode, input int stop_after);
        int a;
        for (int k = 0; k < len; k++) begin
            a = (base + k * ELEMS) % N;
            addrq.push_back(a);
            expq.push_back(word_of(a));
            lastq.push_back(k == len - 1);
        end
        done_seen  = 0;
        first_seen = 0;
        issued     = 0;
        popped     = 0;
        prev_stall = 0;
        bus.base_addr_i = AW'(base);
        bus.len_i       = (AW+1)'(len);
        bus.start_i     = 1'b1;
        bus.m_ready_i   = 1'b1;
        start_cyc       = cyc;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            cycle();
            bus.start_i = 1'b0;
            if (mode == 1) bus.m_ready_i = (i % 2 == 1);
            if (mode == 2 && i == 1) begin
                bus.start_i     = 1'b1;
                bus.base_addr_i = AW'(300);
                bus.len_i       = (AW+1)'(5);
            end
            if (stop_after > 0 && popped >= stop_after) break;
        end
        if (stop_after == 0) begin
            check("done_seen", 64'(done_seen), 64'd1);
            check("addr_left", 64'(addrq.size()), 64'd0);
            check("data_left", 64'(expq.size()), 64'd0);
            check("done_after_last_hs", 64'(done_cyc), 64'(last_hs_cyc + 1));
            check("first_valid_lat", 64'(first_cyc - start_cyc), 64'd2);
            if (mode == 0) check("burst_cycles", 64'(done_cyc - start_cyc), 64'(len + 2));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(bus.busy_o),      64'd0);
        check({tag, "_done"},  64'(bus.done_o),      64'd0);
        check({tag, "_en"},    64'(bus.sram_en_o),   64'd0);
        check({tag, "_we"},    64'(bus.sram_we_o),   64'd0);
        check({tag, "_addr"},  64'(bus.sram_addr_o), 64'd0);
        check({tag, "_valid"}, 64'(bus.m_valid_o),   64'd0);
        check({tag, "_data"},  bus.m_data_o,         64'd0);
`ifdef SRAM_STREAM_LAST_EN
        check({tag, "_last"},  64'(bus.m_last_o),    64'd0);
`endif
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.m_ready_i   = 1'b1;
        #3;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_burst(0, 4, 0, 0);
        run_burst(100, 8, 1, 0);
        run_burst(1020, 4, 0, 0);

        // Zero length: done next cycle, no read, stays idle; a start in that done cycle is taken
        bus.base_addr_i = AW'(10);
        bus.len_i       = '0;
        bus.start_i     = 1'b1;
        start_cyc       = cyc;
        #1;
        check("zero_en", 64'(bus.sram_en_o), 64'd0);
        check("zero_busy0", 64'(bus.busy_o), 64'd0);
        #1;
        cycle();
        bus.start_i = 1'b0;
        check("zero_done", 64'(bus.done_o), 64'd1);
        check("zero_busy1", 64'(bus.busy_o), 64'd0);
        check("zero_en1", 64'(bus.sram_en_o), 64'd0);
        run_burst(40, 1, 0, 0);

        run_burst(500, 3, 2, 0);

        // Reset after three of eight words
        run_burst(200, 8, 0, 3);
        check("words_before_rst", 64'(popped), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        addrq.delete();
        expq.delete();
        lastq.delete();
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("no_done_in_rst", 64'(bus.done_o), 64'd0);
        end
        rst_n = 1'b1;
        run_burst(8, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
